// File: rtl/ppi_pkg.sv
// Shared definitions for the PPI link transmitter and receiver.
package ppi_pkg;

    localparam logic [15:0] START_WORD     = 16'hFFFF;

    localparam logic [15:0] CODE_TIME_DIAG = 16'hFFF0;
    localparam logic [15:0] CODE_DDS       = 16'hFFF1;
    localparam logic [15:0] CODE_DDS_1     = 16'hFFD1;

    localparam logic [15:0] EVT_TNO        = 16'h0001;
    localparam logic [15:0] EVT_TOBM       = 16'h000D;
    localparam logic [15:0] EVT_DTNC       = 16'h000E;
    localparam logic [15:0] EVT_END        = 16'h00FF;

    localparam int unsigned FRAME_LEN_DEFAULT = 256;
    localparam int unsigned TIMEOUT_DEFAULT   = 1024;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StRecv,
        StDone
    } ppi_state_e;

endpackage

// File: rtl/ppi_sync_edge.sv
// Two-flop synchroniser for one asynchronous bit with a rising-edge detector.
module ppi_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_sync = r_s2;
    assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/ppi_rx.sv
// PPI link receiver: syncs fs/strobe/data, frames words, checks start and XOR check word.
module ppi_rx #(
    parameter int unsigned FRAME_LEN  = ppi_pkg::FRAME_LEN_DEFAULT,
    parameter logic [15:0] START_WORD = ppi_pkg::START_WORD,
    parameter int unsigned TIMEOUT    = ppi_pkg::TIMEOUT_DEFAULT
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_fs,
    input  logic                         i_clk_ppi,
    input  logic [15:0]                  i_data_ppi,
    output logic [15:0]                  o_word_data,
    output logic                         o_word_valid,
    output logic [$clog2(FRAME_LEN)-1:0] o_word_idx,
    output logic [15:0]                  o_cmd_code,
    output logic [15:0]                  o_sub_code,
    output logic                         o_frame_done,
    output logic                         o_crc_ok,
    output logic                         o_err_start,
    output logic                         o_err_resync,
    output logic                         o_err_timeout
);
    import ppi_pkg::*;

    localparam int unsigned IDX_W = $clog2(FRAME_LEN);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic w_fs_sync, w_fs_rise, w_stb_sync, w_stb_rise;
    logic [15:0] r_data_s1, r_data_s2;

    ppi_state_e r_state, w_state_d;
    logic [IDX_W-1:0] r_idx, w_idx_d, r_word_idx, w_word_idx_d;
    logic [TMO_W-1:0] r_tmo, w_tmo_d;
    logic [15:0] r_chk, w_chk_d, r_sh1, w_sh1_d, r_sh2, w_sh2_d;
    logic [15:0] r_word_data, w_word_data_d, r_cmd, w_cmd_d, r_sub, w_sub_d;
    logic r_match, w_match_d, r_word_valid, w_word_valid_d, r_done, w_done_d;
    logic r_crc_ok, w_crc_ok_d, r_e_start, w_e_start_d, r_e_resync, w_e_resync_d;
    logic r_e_tmo, w_e_tmo_d;

    ppi_sync_edge u_fs_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_fs),
        .o_sync  (w_fs_sync),
        .o_rise  (w_fs_rise)
    );

    ppi_sync_edge u_stb_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_clk_ppi),
        .o_sync  (w_stb_sync),
        .o_rise  (w_stb_rise)
    );

    always_comb begin
        w_state_d      = r_state;
        w_idx_d        = r_idx;
        w_tmo_d        = r_tmo + 1'b1;
        w_chk_d        = r_chk;
        w_sh1_d        = r_sh1;
        w_sh2_d        = r_sh2;
        w_match_d      = r_match;
        w_word_data_d  = r_word_data;
        w_word_idx_d   = r_word_idx;
        w_word_valid_d = 1'b0;
        w_done_d       = 1'b0;
        w_crc_ok_d     = r_crc_ok;
        w_cmd_d        = r_cmd;
        w_sub_d        = r_sub;
        w_e_start_d    = 1'b0;
        w_e_resync_d   = 1'b0;
        w_e_tmo_d      = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_tmo_d = '0;
                if (w_fs_rise) w_state_d = StArmed;
            end
            StArmed: begin
                // Enter RECV with the strobe low so the first rise seen is a full word.
                if (!w_fs_sync && !w_stb_sync) begin
                    w_state_d = StRecv;
                    w_idx_d   = '0;
                    w_chk_d   = '0;
                    w_tmo_d   = '0;
                end else if (r_tmo == TMO_LAST) begin
                    w_state_d = StIdle;
                    w_e_tmo_d = 1'b1;
                end
            end
            StRecv: begin
                if (w_fs_rise) begin
                    w_state_d    = StArmed;
                    w_e_resync_d = 1'b1;
                    w_tmo_d      = '0;
                end else if (w_stb_rise) begin
                    w_tmo_d        = '0;
                    w_word_data_d  = r_data_s2;
                    w_word_idx_d   = r_idx;
                    w_word_valid_d = 1'b1;
                    w_idx_d        = r_idx + 1'b1;
                    if (r_idx != LAST_IDX) w_chk_d = r_chk ^ r_data_s2;
                    if (r_idx == IDX_W'(1)) w_sh1_d = r_data_s2;
                    if (r_idx == IDX_W'(2)) w_sh2_d = r_data_s2;
                    if (r_idx == '0 && r_data_s2 != START_WORD) begin
                        w_state_d   = StIdle;
                        w_e_start_d = 1'b1;
                    end else if (r_idx == LAST_IDX) begin
                        w_state_d = StDone;
                        w_idx_d   = r_idx;
                        w_match_d = (r_data_s2 == r_chk);
                    end
                end else if (r_tmo == TMO_LAST) begin
                    w_state_d = StIdle;
                    w_e_tmo_d = 1'b1;
                end
            end
            StDone: begin
                w_done_d   = 1'b1;
                w_crc_ok_d = r_match;
                w_tmo_d    = '0;
                if (r_match) begin
                    w_cmd_d = r_sh1;
                    w_sub_d = r_sh2;
                end
                w_state_d = w_fs_rise ? StArmed : StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data_s1    <= '0;
            r_data_s2    <= '0;
            r_state      <= StIdle;
            r_idx        <= '0;
            r_tmo        <= '0;
            r_chk        <= '0;
            r_sh1        <= '0;
            r_sh2        <= '0;
            r_match      <= 1'b0;
            r_word_data  <= '0;
            r_word_idx   <= '0;
            r_word_valid <= 1'b0;
            r_done       <= 1'b0;
            r_crc_ok     <= 1'b0;
            r_cmd        <= '0;
            r_sub        <= '0;
            r_e_start    <= 1'b0;
            r_e_resync   <= 1'b0;
            r_e_tmo      <= 1'b0;
        end else begin
            r_data_s1    <= i_data_ppi;
            r_data_s2    <= r_data_s1;
            r_state      <= w_state_d;
            r_idx        <= w_idx_d;
            r_tmo        <= w_tmo_d;
            r_chk        <= w_chk_d;
            r_sh1        <= w_sh1_d;
            r_sh2        <= w_sh2_d;
            r_match      <= w_match_d;
            r_word_data  <= w_word_data_d;
            r_word_idx   <= w_word_idx_d;
            r_word_valid <= w_word_valid_d;
            r_done       <= w_done_d;
            r_crc_ok     <= w_crc_ok_d;
            r_cmd        <= w_cmd_d;
            r_sub        <= w_sub_d;
            r_e_start    <= w_e_start_d;
            r_e_resync   <= w_e_resync_d;
            r_e_tmo      <= w_e_tmo_d;
        end
    end

    assign o_word_data   = r_word_data;
    assign o_word_valid  = r_word_valid;
    assign o_word_idx    = r_word_idx;
    assign o_cmd_code    = r_cmd;
    assign o_sub_code    = r_sub;
    assign o_frame_done  = r_done;
    assign o_crc_ok      = r_crc_ok;
    assign o_err_start   = r_e_start;
    assign o_err_resync  = r_e_resync;
    assign o_err_timeout = r_e_tmo;

endmodule

// File: tb/tb_ppi_rx.sv
// Directed bench for ppi_rx: table of whole frames plus resync, timeout and reset sequences.
module tb_ppi_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fs = 1'b0;
    logic        clk_ppi = 1'b0;
    logic [15:0] data_ppi = '0;
    logic [15:0] word_data, cmd_code, sub_code;
    logic [7:0]  word_idx;
    logic        word_valid, frame_done, crc_ok, err_start, err_resync, err_timeout;

    ppi_rx dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_fs          (fs),
        .i_clk_ppi     (clk_ppi),
        .i_data_ppi    (data_ppi),
        .o_word_data   (word_data),
        .o_word_valid  (word_valid),
        .o_word_idx    (word_idx),
        .o_cmd_code    (cmd_code),
        .o_sub_code    (sub_code),
        .o_frame_done  (frame_done),
        .o_crc_ok      (crc_ok),
        .o_err_start   (err_start),
        .o_err_resync  (err_resync),
        .o_err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] w0, w1, w2, last;
        int          n_valid, n_done, n_estart;
        logic        crc;
        logic [15:0] cmd, sub;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor, sampled on the falling edge.
    int n_valid, n_done, n_estart, n_eresync, n_etmo;
    int cyc = 0, last_valid_cyc = 0, tmo_cyc = 0;
    logic [15:0] got_data [0:511];
    logic [7:0]  got_idx  [0:511];

    always @(negedge clk) begin
        cyc++;
        if (word_valid) begin
            if (n_valid < 512) begin
                got_data[n_valid] = word_data;
                got_idx[n_valid]  = word_idx;
            end
            n_valid++;
            last_valid_cyc = cyc;
        end
        if (frame_done) n_done++;
        if (err_start) n_estart++;
        if (err_resync) n_eresync++;
        if (err_timeout) begin
            n_etmo++;
            tmo_cyc = cyc;
        end
    end

    task automatic clear_mon();
        n_valid = 0; n_done = 0; n_estart = 0; n_eresync = 0; n_etmo = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_word(input vec_t v, input int k);
        if (k == 0) return v.w0;
        if (k == 1) return v.w1;
        if (k == 2) return v.w2;
        if (k == 255) return v.last;
        return 16'(k);
    endfunction

    task automatic frame_start();
        fs = 1'b1;
        clk_ppi = 1'b0;
        repeat (3) tick();
        fs = 1'b0;
        repeat (4) tick();
    endtask

    task automatic send_word(input logic [15:0] w);
        clk_ppi = 1'b0;
        data_ppi = w;
        repeat (2) tick();
        clk_ppi = 1'b1;
        repeat (2) tick();
    endtask

    task automatic send_frame(input vec_t v, input int nwords);
        frame_start();
        for (int k = 0; k < nwords; k++) send_word(exp_word(v, k));
        repeat (10) tick();
    endtask

    task automatic check_seq(input string name, input vec_t v, input int first, input int cnt);
        int bad_idx = 0;
        int bad_dat = 0;
        for (int i = 0; i < cnt; i++) begin
            if (got_idx[first + i] !== 8'(i)) bad_idx++;
            if (got_data[first + i] !== exp_word(v, i)) bad_dat++;
        end
        check({name, " idx_seq_errs"}, bad_idx, 0);
        check({name, " data_seq_errs"}, bad_dat, 0);
    endtask

    vec_t vecs [5];
    vec_t good;

    initial begin
        // Check words: FFFF^FFF1^FFD1^(3^..^254) = FF23; FFFF^(1^..^254) = FF00.
        vecs[0] = '{"good", 16'hFFFF, 16'hFFF1, 16'hFFD1, 16'hFF23, 256, 1, 0, 1'b1,
                    16'hFFF1, 16'hFFD1};
        vecs[1] = '{"xor_ok", 16'hFFFF, 16'h0001, 16'h0002, 16'hFF00, 256, 1, 0, 1'b1,
                    16'h0001, 16'h0002};
        vecs[2] = '{"xor_bad", 16'hFFFF, 16'h0001, 16'h0002, 16'hFF01, 256, 1, 0, 1'b0,
                    16'h0001, 16'h0002};
        vecs[3] = '{"bad_start", 16'hFFFE, 16'hFFF0, 16'hFFD1, 16'hFF23, 1, 0, 1, 1'b0,
                    16'h0001, 16'h0002};
        vecs[4] = '{"good_again", 16'hFFFF, 16'hFFF1, 16'hFFD1, 16'hFF23, 256, 1, 0, 1'b1,
                    16'hFFF1, 16'hFFD1};
        good = vecs[0];

        clear_mon();
        repeat (3) tick();
        check("reset outputs", {word_data, cmd_code, sub_code, word_idx, word_valid,
              frame_done, crc_ok, err_start, err_resync, err_timeout}, '0);
        check("reset cmd_code", {16'h0, cmd_code}, 0);
        rst_n = 1'b1;
        repeat (3) tick();

        for (int r = 0; r < 5; r++) begin
            clear_mon();
            send_frame(vecs[r], 256);
            check({vecs[r].name, " n_valid"}, n_valid, vecs[r].n_valid);
            check({vecs[r].name, " n_done"}, n_done, vecs[r].n_done);
            check({vecs[r].name, " n_err_start"}, n_estart, vecs[r].n_estart);
            check({vecs[r].name, " other_errs"}, n_eresync + n_etmo, 0);
            check({vecs[r].name, " crc_ok"}, crc_ok, vecs[r].crc);
            check({vecs[r].name, " cmd_code"}, cmd_code, vecs[r].cmd);
            check({vecs[r].name, " sub_code"}, sub_code, vecs[r].sub);
            check_seq(vecs[r].name, vecs[r], 0, (n_valid < 256) ? n_valid : 256);
        end

        // Resync after word 100, then a full good frame.
        clear_mon();
        send_frame(good, 101);
        send_frame(good, 256);
        check("resync n_err_resync", n_eresync, 1);
        check("resync n_done", n_done, 1);
        check("resync n_valid", n_valid, 357);
        check("resync crc_ok", crc_ok, 1);
        check("resync idx_restart", got_idx[101], 0);
        check_seq("resync frame2", good, 101, 256);

        // Strobe stops after word 50.
        clear_mon();
        frame_start();
        for (int k = 0; k <= 50; k++) send_word(exp_word(good, k));
        repeat (1100) tick();
        check("timeout n_err_timeout", n_etmo, 1);
        check("timeout latency", tmo_cyc - last_valid_cyc, 1024);
        check("timeout n_done", n_done, 0);
        for (int k = 0; k < 5; k++) send_word(16'(k));
        repeat (6) tick();
        check("timeout idle n_valid", n_valid, 51);

        // Reset in the middle of a frame.
        clear_mon();
        frame_start();
        for (int k = 0; k < 30; k++) send_word(exp_word(good, k));
        rst_n = 1'b0;
        #1;
        check("midreset outputs", {word_data, cmd_code, sub_code, word_idx, word_valid,
              frame_done, crc_ok, err_start, err_resync, err_timeout}, '0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        clear_mon();
        send_frame(good, 256);
        check("post_reset n_valid", n_valid, 256);
        check("post_reset n_done", n_done, 1);
        check("post_reset crc_ok", crc_ok, 1);
        check("post_reset cmd_code", cmd_code, 16'hFFF1);
        check("post_reset sub_code", sub_code, 16'hFFD1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
